scalar_mult_sequencer: RTL and testbench

- Controls the double-and-add scalar multiplication k·G that the ECDSA signing top needs for the public key and the nonce point.
- Takes a validated 256-bit scalar and issues LOAD_G / DBL / ADD commands, MSB-first, to the shared point-arithmetic unit over a valid/ready + done handshake.
- Rejects the scalar before any command if k == 0 or k ≥ N.
- Holds no curve coordinates; the point unit owns the accumulator R.

---
 rtl/ecc_ctrl_pkg.sv | 34 +++
 rtl/key_msb_encoder.sv | 30 +++
 rtl/scalar_mult_sequencer.sv | 142 ++++++++++++++
 tb/tb_scalar_mult_sequencer.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/ecc_ctrl_pkg.sv
// ============================================================================
//  Module      : ecc_ctrl_pkg
//  Description : Shared types and constants for the ECDSA point-op controllers
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ecc_ctrl_pkg;

    localparam logic [255:0] SECP256K1_N =
        256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEBAAEDCE6AF48A03BBFD25E8CD0364141;

    typedef enum logic [1:0] {
        OP_LOAD_G = 2'd0,
        OP_DBL    = 2'd1,
        OP_ADD    = 2'd2
    } op_t;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_CHECK     = 4'd1,
        ST_ERR       = 4'd2,
        ST_LOAD      = 4'd3,
        ST_LOAD_WAIT = 4'd4,
        ST_DBL       = 4'd5,
        ST_DBL_WAIT  = 4'd6,
        ST_ADD       = 4'd7,
        ST_ADD_WAIT  = 4'd8,
        ST_FIN       = 4'd9
    } seq_state_t;

endpackage

`default_nettype wire

// File: rtl/key_msb_encoder.sv
// ============================================================================
//  Module      : key_msb_encoder
//  Description : Combinational priority encoder: index of highest set bit
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module key_msb_encoder #(
    parameter int unsigned KEY_W = 256
) (
    input  logic [KEY_W-1:0]         key_i,
    output logic [$clog2(KEY_W)-1:0] msb_idx_o,
    output logic                     zero_o
);

    // Ascending scan: the last set bit seen wins, giving the MSB.
    always_comb begin
        msb_idx_o = '0;
        for (int i = 0; i < KEY_W; i++) begin
            if (key_i[i]) begin
                msb_idx_o = ($clog2(KEY_W))'(i);
            end
        end
    end

    assign zero_o = ~|key_i;

endmodule

`default_nettype wire

// File: rtl/scalar_mult_sequencer.sv
// ============================================================================
//  Module      : scalar_mult_sequencer
//  Description : MSB-first double-and-add command sequencer for k*G
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module scalar_mult_sequencer
    import ecc_ctrl_pkg::*;
#(
    parameter int unsigned      KEY_W   = 256,
    parameter logic [KEY_W-1:0] CURVE_N = KEY_W'(SECP256K1_N)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [KEY_W-1:0]         priv_key,
    output logic                     busy,
    output logic                     done,
    output logic                     invalid_error,
    output logic                     op_valid,
    output logic [1:0]               op_code,
    input  logic                     op_ready,
    input  logic                     op_done,
    output logic [$clog2(KEY_W)-1:0] bit_idx,
    output logic [9:0]               ops_issued
);

    localparam int unsigned IDX_W = $clog2(KEY_W);

    seq_state_t         state_q, state_d;
    logic [KEY_W-1:0]   key_q, key_d;
    logic [IDX_W-1:0]   bit_idx_q, bit_idx_d;
    logic [9:0]         ops_q, ops_d;
    logic               inv_q, inv_d;
    logic [IDX_W-1:0]   msb_idx;
    logic               key_zero;
    op_t                op_d;

    key_msb_encoder #(
        .KEY_W (KEY_W)
    ) u_msb_enc (
        .key_i     (key_q),
        .msb_idx_o (msb_idx),
        .zero_o    (key_zero)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            key_q     <= '0;
            bit_idx_q <= '0;
            ops_q     <= '0;
            inv_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            key_q     <= key_d;
            bit_idx_q <= bit_idx_d;
            ops_q     <= ops_d;
            inv_q     <= inv_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        key_d     = key_q;
        bit_idx_d = bit_idx_q;
        ops_d     = ops_q;
        inv_d     = inv_q;
        op_d      = OP_LOAD_G;
        op_valid  = 1'b0;
        done      = 1'b0;
        busy      = (state_q != ST_IDLE);

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    key_d   = priv_key;
                    inv_d   = 1'b0;
                    ops_d   = '0;
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (key_zero || (key_q >= CURVE_N)) begin
                    inv_d   = 1'b1;
                    state_d = ST_ERR;
                end else begin
                    bit_idx_d = msb_idx;
                    state_d   = ST_LOAD;
                end
            end
            ST_ERR: state_d = ST_IDLE;
            ST_LOAD, ST_DBL, ST_ADD: begin
                op_valid = 1'b1;
                op_d     = (state_q == ST_LOAD) ? OP_LOAD_G :
                           (state_q == ST_DBL)  ? OP_DBL    : OP_ADD;
                if (op_ready) begin
                    ops_d   = ops_q + 10'd1;
                    state_d = (state_q == ST_LOAD) ? ST_LOAD_WAIT :
                              (state_q == ST_DBL)  ? ST_DBL_WAIT  : ST_ADD_WAIT;
                end
            end
            ST_LOAD_WAIT, ST_ADD_WAIT: begin
                if (op_done) begin
                    if (bit_idx_q == '0) begin
                        state_d = ST_FIN;
                    end else begin
                        bit_idx_d = bit_idx_q - IDX_W'(1);
                        state_d   = ST_DBL;
                    end
                end
            end
            ST_DBL_WAIT: begin
                // A set bit at the current position needs an ADD before moving on.
                if (op_done) begin
                    if (key_q[bit_idx_q]) begin
                        state_d = ST_ADD;
                    end else if (bit_idx_q == '0) begin
                        state_d = ST_FIN;
                    end else begin
                        bit_idx_d = bit_idx_q - IDX_W'(1);
                        state_d   = ST_DBL;
                    end
                end
            end
            ST_FIN: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign op_code       = op_d;
    assign invalid_error = inv_q;
    assign bit_idx       = bit_idx_q;
    assign ops_issued    = ops_q;

endmodule

`default_nettype wire

// File: tb/tb_scalar_mult_sequencer.sv
// ============================================================================
//  Module      : tb_scalar_mult_sequencer
//  Description : Randomized bench with a point-unit responder and k*G model
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_scalar_mult_sequencer;

    localparam logic [255:0] N =
        256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEBAAEDCE6AF48A03BBFD25E8CD0364141;

    logic         clk;
    logic         reset;
    logic         start;
    logic [255:0] priv_key;
    logic         busy, done, invalid_error, op_valid;
    logic [1:0]   op_code;
    logic         op_ready, op_done;
    logic [7:0]   bit_idx;
    logic [9:0]   ops_issued;

    scalar_mult_sequencer dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .priv_key      (priv_key),
        .busy          (busy),
        .done          (done),
        .invalid_error (invalid_error),
        .op_valid      (op_valid),
        .op_code       (op_code),
        .op_ready      (op_ready),
        .op_done       (op_done),
        .bit_idx       (bit_idx),
        .ops_issued    (ops_issued)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    logic [1:0] log_q[$];
    logic [1:0] exp_q[$];
    int         exp_m;
    bit         rnd_g, spur_g, valid_seen, prev_stall;
    int         stall_cnt, done_cnt, done_seen;
    logic [1:0] prev_code;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Textbook left-to-right double-and-add: G, then per lower bit DBL (+ADD if set).
    function automatic void build_ref(input logic [255:0] k);
        exp_q.delete();
        exp_m = 0;
        if (k == 0 || k >= N) return;
        for (int i = 0; i < 256; i++) if (k[i]) exp_m = i;
        exp_q.push_back(2'd0);
        for (int i = exp_m - 1; i >= 0; i--) begin
            exp_q.push_back(2'd1);
            if (k[i]) exp_q.push_back(2'd2);
        end
    endfunction

    // One clock of the point-unit responder, evaluated at the falling edge.
    task automatic cycle();
        @(negedge clk);
        op_done = 1'b0;
        if (done_cnt > 0) begin
            done_cnt--;
            if (done_cnt == 0) op_done = 1'b1;
        end
        if (prev_stall && op_valid) check("op_code_stable", 256'(op_code), 256'(prev_code));
        op_ready = (stall_cnt == 0);
        if (stall_cnt > 0) stall_cnt--;
        if (op_valid) valid_seen = 1'b1;
        if (done) done_seen++;
        if (op_valid && op_ready) begin
            if (log_q.size() == 0) check("bit_idx_msb", 256'(bit_idx), 256'(exp_m));
            log_q.push_back(op_code);
            done_cnt  = 2;
            stall_cnt = rnd_g ? int'($urandom_range(0, 5)) : 0;
        end else if (spur_g && op_valid && done_cnt == 0 && $urandom_range(0, 1) == 1) begin
            op_done = 1'b1;
        end
        prev_stall = op_valid && !op_ready;
        prev_code  = op_code;
    endtask

    task automatic begin_job(input logic [255:0] k, input bit rnd, input bit spur);
        build_ref(k);
        rnd_g      = rnd;
        spur_g     = spur;
        log_q.delete();
        done_seen  = 0;
        valid_seen = 1'b0;
        stall_cnt  = rnd ? int'($urandom_range(0, 5)) : 0;
        priv_key   = k;
        start      = 1'b1;
    endtask

    task automatic run_job(input logic [255:0] k, input bit rnd, input bit spur, input bit noise);
        int s, inv_first, busy_drop, done_step;
        bit valid;
        begin_job(k, rnd, spur);
        valid = (exp_q.size() != 0);
        s = 0; inv_first = 0; busy_drop = 0; done_step = 0;
        do begin
            cycle();
            s++;
            start = 1'b0;
            if (noise && busy && !done && $urandom_range(0, 3) == 0) begin
                start    = 1'b1;
                priv_key = {8{$urandom}};
            end
            if (s == 1) begin
                check("busy_after_start", 256'(busy), 256'(1));
                check("inv_cleared", 256'(invalid_error), 256'(0));
            end
            if (invalid_error && inv_first == 0) inv_first = s;
            if (done && done_step == 0) done_step = s;
            if (!busy) busy_drop = s;
        end while (busy && s < 20000);
        start = 1'b0;
        if (s >= 20000) check("timeout", 256'(busy), 256'(0));
        repeat (3) cycle();
        check("done_count", 256'(done_seen), valid ? 256'(1) : 256'(0));
        check("invalid_error", 256'(invalid_error), valid ? 256'(0) : 256'(1));
        check("op_valid_seen", 256'(valid_seen), 256'(valid));
        check("ops_issued", 256'(ops_issued), 256'(exp_q.size()));
        check("op_count", 256'(log_q.size()), 256'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
            check("op_seq", 256'(log_q[i]), 256'(exp_q[i]));
        if (valid) begin
            check("busy_drop_after_done", 256'(busy_drop), 256'(done_step + 1));
        end else begin
            check("inv_latency", 256'(inv_first), 256'(2));
            check("inv_busy_drop", 256'(busy_drop), 256'(3));
        end
    endtask

    initial begin
        int s;
        reset = 1'b0; start = 1'b0; priv_key = '0; op_ready = 1'b0; op_done = 1'b0;
        rnd_g = 0; spur_g = 0; prev_stall = 0; stall_cnt = 0; done_cnt = 0; done_seen = 0;
        prev_code = '0; exp_m = 0; valid_seen = 0;
        @(negedge clk);
        #1;
        check("rst_busy", 256'(busy), 256'(0));
        check("rst_done", 256'(done), 256'(0));
        check("rst_inv", 256'(invalid_error), 256'(0));
        check("rst_valid", 256'(op_valid), 256'(0));
        check("rst_code", 256'(op_code), 256'(0));
        check("rst_bit_idx", 256'(bit_idx), 256'(0));
        check("rst_ops", 256'(ops_issued), 256'(0));
        @(negedge clk);
        reset = 1'b1;

        run_job(256'd6, 0, 0, 0);
        run_job(256'd1, 0, 0, 0);
        check("k1_bit_idx", 256'(bit_idx), 256'(0));
        run_job(256'd0, 0, 0, 0);
        run_job(N, 0, 0, 0);
        run_job(256'd6, 0, 0, 0);
        run_job(N - 256'd1, 1, 0, 0);
        run_job(256'd6, 1, 1, 1);
        run_job(256'($urandom_range(1, 255)), 1, 1, 1);
        for (int j = 0; j < 2; j++) run_job({8{$urandom}}, 1, 0, 0);

        // Abort a k=6 job while the first DBL is outstanding.
        begin_job(256'd6, 0, 0);
        s = 0;
        do begin
            cycle();
            s++;
            start = 1'b0;
        end while (log_q.size() < 2 && s < 200);
        check("abort_setup", 256'(log_q.size()), 256'(2));
        cycle();
        #2 reset = 1'b0;
        #1;
        check("abort_busy", 256'(busy), 256'(0));
        check("abort_done", 256'(done), 256'(0));
        check("abort_inv", 256'(invalid_error), 256'(0));
        check("abort_valid", 256'(op_valid), 256'(0));
        check("abort_code", 256'(op_code), 256'(0));
        check("abort_bit_idx", 256'(bit_idx), 256'(0));
        check("abort_ops", 256'(ops_issued), 256'(0));
        done_cnt = 0; op_done = 1'b0; prev_stall = 1'b0; stall_cnt = 0;
        @(negedge clk);
        reset = 1'b1;
        run_job(256'd5, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
